// File: rtl/par_to_ser_tx_pkg.sv
// Shared definitions for the parallel-to-serial transmit path: default word
// width (common with the matching deserializer) and the transmit FSM encoding.
package par_to_ser_tx_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/par_to_ser_tx_piso_shift_core.sv
// Shift core: keeps the not-yet-sent bits of the current word and a bit counter.
// The first bit of a word goes straight to the output register on the load edge.
module piso_shift_core
    import par_to_ser_tx_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_word,
    output logic             first_bit,
    output logic             next_bit,
    output logic             last_bit
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int REM_W = WIDTH - 1;

    logic [REM_W-1:0] rem_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [REM_W-1:0] load_rem_s;

    // Only WIDTH-1 bits are stored: the first bit is presented on the load edge.
    assign load_rem_s = (MSB_FIRST != 0) ? load_word[WIDTH-2:0] : load_word[WIDTH-1:1];
    assign first_bit  = (MSB_FIRST != 0) ? load_word[WIDTH-1] : load_word[0];
    assign next_bit   = (MSB_FIRST != 0) ? rem_r[REM_W-1] : rem_r[0];
    assign last_bit   = (bit_cnt_r == CNT_W'(WIDTH - 1));

    // Remaining-bits register and position counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r     <= {REM_W{1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            rem_r     <= load_rem_s;
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (shift) begin
            rem_r     <= (MSB_FIRST != 0) ? (rem_r << 1'b1) : (rem_r >> 1'b1);
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end else begin
            rem_r     <= rem_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

endmodule

// File: rtl/par_to_ser_tx.sv
// Parallel-to-serial transmitter: valid/ready word intake into a one-entry hold
// buffer, then one bit per clock on ser_out with a frame_start marker per word.
module par_to_ser_tx
    import par_to_ser_tx_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] par_in,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    tx_state_e        state_r, state_nxt_s;
    logic [WIDTH-1:0] hold_word_r;
    logic             hold_full_r;
    logic             ser_out_r, ser_valid_r, frame_start_r;
    logic             ser_out_nxt_s, ser_valid_nxt_s, frame_start_nxt_s;
    logic             load_now_s, shift_s, accept_s;
    logic             first_bit_s, next_bit_s, last_bit_s;

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load_now_s),
        .shift     (shift_s),
        .load_word (hold_word_r),
        .first_bit (first_bit_s),
        .next_bit  (next_bit_s),
        .last_bit  (last_bit_s)
    );

    // Ready depends only on registered state (and reset), never on par_valid.
    assign par_ready   = ~reset & (~hold_full_r | load_now_s);
    assign accept_s    = par_valid & par_ready;
    assign busy        = hold_full_r | (state_r == ST_SHIFT);
    assign ser_out     = ser_out_r;
    assign ser_valid   = ser_valid_r;
    assign frame_start = frame_start_r;

    // Next-state and next-output decode for the transmit FSM.
    always_comb begin
        state_nxt_s       = state_r;
        load_now_s        = 1'b0;
        shift_s           = 1'b0;
        ser_out_nxt_s     = IDLE_LEVEL;
        ser_valid_nxt_s   = 1'b0;
        frame_start_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold_full_r) begin
                    load_now_s        = 1'b1;
                    state_nxt_s       = ST_SHIFT;
                    ser_out_nxt_s     = first_bit_s;
                    ser_valid_nxt_s   = 1'b1;
                    frame_start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!last_bit_s) begin
                    shift_s         = 1'b1;
                    ser_out_nxt_s   = next_bit_s;
                    ser_valid_nxt_s = 1'b1;
                end else if (hold_full_r) begin
                    // Back-to-back word: reload on the last-bit edge, no gap.
                    load_now_s        = 1'b1;
                    state_nxt_s       = ST_SHIFT;
                    ser_out_nxt_s     = first_bit_s;
                    ser_valid_nxt_s   = 1'b1;
                    frame_start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Hold buffer: a same-edge accept refills it while the old word is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_word_r <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_word_r <= par_in;
            hold_full_r <= 1'b1;
        end else if (load_now_s) begin
            hold_word_r <= hold_word_r;
            hold_full_r <= 1'b0;
        end else begin
            hold_word_r <= hold_word_r;
            hold_full_r <= hold_full_r;
        end
    end

    // FSM state and registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            ser_out_r     <= IDLE_LEVEL;
            ser_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ser_out_r     <= ser_out_nxt_s;
            ser_valid_r   <= ser_valid_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

endmodule

// File: tb/tb_par_to_ser_tx.sv
// Bench for par_to_ser_tx: MSB-first and LSB-first instances share stimulus;
// a bit-level scoreboard plus a word reassembler check both serial streams.
module tb_par_to_ser_tx;

    typedef struct {
        logic b;
        logic first;
    } sb_t;

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] par_in;
    logic       par_valid;
    logic       ready_m, so_m, sv_m, fs_m, busy_m;
    logic       ready_l, so_l, sv_l, fs_l, busy_l;

    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    sb_t        q_m[$], q_l[$];
    logic [7:0] rm[$], rl[$];
    logic [7:0] rx_m, rx_l;
    int         rc_m, rc_l, run_m, run_l, last_run_m, last_run_l;

    always #5 clk = ~clk;

    par_to_ser_tx #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .reset(reset), .par_in(par_in), .par_valid(par_valid),
        .par_ready(ready_m), .ser_out(so_m), .ser_valid(sv_m),
        .frame_start(fs_m), .busy(busy_m)
    );

    par_to_ser_tx #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .reset(reset), .par_in(par_in), .par_valid(par_valid),
        .par_ready(ready_l), .ser_out(so_l), .ser_valid(sv_l),
        .frame_start(fs_l), .busy(busy_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Scoreboard push: every accepted word yields 8 expected bits per instance.
    always @(posedge clk) begin
        if (!reset && par_valid && ready_m) begin
            for (int i = 0; i < 8; i++) begin
                q_m.push_back(sb_t'{b: par_in[7-i], first: (i == 0)});
                q_l.push_back(sb_t'{b: par_in[i], first: (i == 0)});
            end
        end
    end

    // Output monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_on) begin
            if (sv_m) begin
                sb_t e;
                run_m++;
                if (q_m.size() == 0) chk("unexpected_bit_m", 32'd1, 32'd0);
                else begin
                    e = q_m.pop_front();
                    chk("bit_m", 32'(so_m), 32'(e.b));
                    chk("frame_start_m", 32'(fs_m), 32'(e.first));
                end
                if (fs_m) begin rx_m = {7'd0, so_m}; rc_m = 1; end
                else begin rx_m = {rx_m[6:0], so_m}; rc_m++; end
                if (rc_m == 8) rm.push_back(rx_m);
            end else begin
                if (run_m != 0) last_run_m = run_m;
                run_m = 0;
                chk("idle_out_m", 32'({so_m, fs_m}), 32'd0);
            end
            if (sv_l) begin
                sb_t e;
                run_l++;
                if (q_l.size() == 0) chk("unexpected_bit_l", 32'd1, 32'd0);
                else begin
                    e = q_l.pop_front();
                    chk("bit_l", 32'(so_l), 32'(e.b));
                    chk("frame_start_l", 32'(fs_l), 32'(e.first));
                end
                if (fs_l) begin rx_l = {7'd0, so_l}; rc_l = 1; end
                else begin rx_l = {rx_l[6:0], so_l}; rc_l++; end
                if (rc_l == 8) rl.push_back(rx_l);
            end else begin
                if (run_l != 0) last_run_l = run_l;
                run_l = 0;
                chk("idle_out_l", 32'({so_l, fs_l}), 32'd0);
            end
        end
    end

    // Offer a word and wait (bounded) for it to be accepted; leaves par_valid high.
    task automatic send(input logic [7:0] w, output int waited);
        logic ok;
        logic done;
        waited = 0;
        done = 1'b0;
        par_in = w;
        par_valid = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            ok = ready_m;
            @(posedge clk);
            #1;
            if (ok) done = 1'b1;
            else waited++;
        end
        if (!done) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            if (q_m.size() == 0 && q_l.size() == 0 && !busy_m && !busy_l) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'd1, 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_rx(input string nm, input logic [7:0] em, input logic [7:0] el);
        if (rm.size() == 0) chk({nm, "_missing_m"}, 32'd0, 32'd1);
        else chk({nm, "_m"}, 32'(rm.pop_front()), 32'(em));
        if (rl.size() == 0) chk({nm, "_missing_l"}, 32'd0, 32'd1);
        else chk({nm, "_l"}, 32'(rl.pop_front()), 32'(el));
    endtask

    initial begin
        vec_t vt[6];
        logic [7:0] sent[$];
        int w;

        vt[0] = '{word: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
        vt[1] = '{word: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
        vt[2] = '{word: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
        vt[3] = '{word: 8'h12, exp_m: 8'h12, exp_l: 8'h48};
        vt[4] = '{word: 8'hC6, exp_m: 8'hC6, exp_l: 8'h63};
        vt[5] = '{word: 8'h0B, exp_m: 8'h0B, exp_l: 8'hD0};
        rx_m = 8'h00; rx_l = 8'h00; rc_m = 0; rc_l = 0;
        run_m = 0; run_l = 0; last_run_m = 0; last_run_l = 0;

        // Reset state
        reset = 1'b1; par_valid = 1'b0; par_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ser_valid", 32'({sv_m, sv_l}), 32'd0);
        chk("rst_ser_out", 32'({so_m, so_l}), 32'd0);
        chk("rst_frame_start", 32'({fs_m, fs_l}), 32'd0);
        chk("rst_busy", 32'({busy_m, busy_l}), 32'd0);
        chk("rst_ready_low", 32'({ready_m, ready_l}), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'({ready_m, ready_l}), 32'd3);
        mon_on = 1'b1;

        // Single word: first bit valid two edges after accept
        send(8'hA5, w);
        par_valid = 1'b0;
        @(negedge clk);
        chk("latency_pre", 32'(sv_m), 32'd0);
        @(negedge clk);
        chk("latency_first", 32'({sv_m, fs_m}), 32'd3);
        drain();
        chk("run_single", 32'(last_run_m), 32'd8);
        expect_rx("word_a5", 8'hA5, 8'hA5);

        // Table-driven single words on both bit orders
        for (int i = 0; i < 6; i++) begin
            send(vt[i].word, w);
            par_valid = 1'b0;
            drain();
            expect_rx("table", vt[i].exp_m, vt[i].exp_l);
            chk("table_run", 32'(last_run_l), 32'd8);
        end

        // Back-to-back words stream without a gap
        send(8'h3C, w);
        send(8'hC3, w);
        par_valid = 1'b0;
        drain();
        chk("run_b2b_m", 32'(last_run_m), 32'd16);
        chk("run_b2b_l", 32'(last_run_l), 32'd16);
        expect_rx("b2b_w0", 8'h3C, 8'h3C);
        expect_rx("b2b_w1", 8'hC3, 8'hC3);

        // Three offers: third stalls until the second loads
        send(8'h11, w);
        chk("stall_w0", 32'(w), 32'd0);
        send(8'h22, w);
        chk("stall_w1", 32'(w), 32'd0);
        send(8'h33, w);
        chk("stall_w2", 32'(w), 32'd7);
        par_valid = 1'b0;
        drain();
        chk("run_three", 32'(last_run_m), 32'd24);
        expect_rx("three_w0", 8'h11, rev8(8'h11));
        expect_rx("three_w1", 8'h22, rev8(8'h22));
        expect_rx("three_w2", 8'h33, rev8(8'h33));

        // Reset mid-word with the next word held
        send(8'hF0, w);
        send(8'h0F, w);
        par_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_pending", 32'(q_m.size()), 32'd13);
        q_m.delete(); q_l.delete(); rm.delete(); rl.delete();
        reset = 1'b0;
        chk("rst_mid_valid", 32'({sv_m, sv_l}), 32'd0);
        chk("rst_mid_busy", 32'({busy_m, busy_l}), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_no_words", 32'(rm.size() + rl.size()), 32'd0);

        // Loopback of random words with random gaps
        for (int i = 0; i < 10; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            sent.push_back(r);
            send(r, w);
            par_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        chk("loop_count_m", 32'(rm.size()), 32'd10);
        chk("loop_count_l", 32'(rl.size()), 32'd10);
        while (sent.size() > 0) begin
            logic [7:0] s;
            s = sent.pop_front();
            expect_rx("loop", s, rev8(s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
